comma_aligner_8b10b: RTL and testbench
======================================

Name: comma_aligner_8b10b

Overview:
Receive-side word aligner that sits directly upstream of decoder_8b10b. It takes raw 10-bit words with an arbitrary bit offset from the deserializer and searches for the K28.5 comma. It locks to the comma boundary and delivers boundary-aligned 10-bit code groups to the decoder's din_dec input. A sync state machine, fed by the decoder's code_err, declares lock and loss of sync.

Parameters:
LOCK_COMMAS, 3, consecutive commas at the same offset needed to go from ACQ to SYNC
LOSS_ERRS, 4, net code-error count in SYNC that forces LOS
GOOD_RUN, 4, consecutive error-free words in SYNC that decrement the error count by 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  word strobe: one new raw word on din per cycle with en=1
din  input  10  raw unaligned word; din[9] is the earliest received bit (bit a)
code_err  input  1  code error from decoder_8b10b for the current decoded word
dout  output  10  aligned code group in abcdeifghj order, dout[9]=a; drives decoder din_dec
dout_valid  output  1  dout holds a new aligned word (state ACQ or SYNC)
comma  output  1  dout contains a comma at the locked boundary
lock  output  1  sync FSM is in SYNC
align_off  output  4  current bit offset, range 0..9

Behaviour:
- Reset (rst=0, asynchronous, also mid-operation):
  - state=LOS; prev, dout, align_off, comma_cnt, err_cnt, good_cnt all 0.
  - dout_valid, comma, lock all 0.
- Window: win[19:0] = {prev, din}. On every en=1 cycle, prev <= din. With en=0 all registers hold, and dout_valid and comma are 0 on the next cycle.
- Candidate k (0..9):
  - Aligned word is win[19-k -: 10].
  - Comma at k if win[19-k -: 7] is 7'b0011111 or 7'b1100000.
  - If several k match, the lowest k wins.
- Output: registered, 1 en-cycle latency. On an en=1 cycle:
  - dout <= win[19-align_off_next -: 10], where align_off_next is the offset chosen this cycle.
  - dout_valid <= (next state != LOS).
  - comma <= comma at align_off_next.
- LOS: search all 10 k each en cycle. On any comma: align_off <= k, comma_cnt <= 1, go to ACQ. Otherwise stay in LOS; dout still updates but dout_valid=0.
- ACQ:
  - Comma at align_off: comma_cnt++. When comma_cnt reaches LOCK_COMMAS, go to SYNC with err_cnt=0 and good_cnt=0.
  - Comma only at a different k: align_off <= k, comma_cnt <= 1, stay in ACQ.
  - code_err=1 with en=1: go to LOS.
  - code_err takes priority over comma counting in the same cycle.
- SYNC:
  - align_off is frozen; commas at other offsets are ignored.
  - On code_err: err_cnt++, good_cnt <= 0.
  - On an error-free word: good_cnt++. When good_cnt reaches GOOD_RUN, good_cnt <= 0 and err_cnt decrements, saturating at 0.
  - When err_cnt reaches LOSS_ERRS: go to LOS; align_off is held until the next comma.
- lock is registered and equals (state==SYNC). It drops on the same edge that enters LOS.
- code_err is sampled only when en=1; ignored in LOS.
- Counter widths are $clog2(param+1); no wrap, since all counters saturate at their limits.

Decomposition:
- Package enc8b10b_pkg holds:
  - COMMA_P = 7'b0011111 and COMMA_N = 7'b1100000;
  - K28_5_RDN = 10'h0FA and K28_5_RDP = 10'h305;
  - the sync state enum {LOS, ACQ, SYNC};
  - the word width constant 10.
- One combinational sub-module, comma_detect_8b10b: takes win[19:0] and returns a 10-bit match vector plus the lowest-index encoded offset.
- FSM, counters and output registers stay in the top level.

Test Plan:
- Aligned stream: alternating 0x0FA/0x305, no shift. Expect align_off=0, LOS→ACQ on the first word, lock=1 after the 3rd comma word, dout alternating 0x0FA/0x305 with comma=1.
- Same stream delayed by 3 bits. Expect align_off=3, lock=1 after 3 commas, dout = 0x0FA/0x305 one en cycle after each word completes.
- In ACQ with comma_cnt=2, the comma moves to offset 7. Expect align_off=7, comma_cnt restarts at 1, lock=1 only after 3 more commas at 7.
- In SYNC, pulse code_err on 4 words separated by 3 good words (fewer than GOOD_RUN). Expect lock=0 on the 4th error edge and dout_valid=0 afterward.
- In SYNC, 3 errors, then 12 good words, then 1 error. Expect err_cnt 3→0 and lock stays 1.
- Assert rst=0 for one cycle mid-stream, plus en=0 gaps. Expect all outputs 0 immediately. Re-acquisition takes 3 commas. Registers hold during en=0, with dout_valid=0.

Source files
------------

// File: rtl/comma_aligner_8b10b_pkg.sv
// Shared 8b/10b constants, sync-state encoding and window helpers for the comma aligner.
package enc8b10b_pkg;

    localparam int WORD_W = 10;

    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } sync_state_e;

    function automatic logic is_comma(input logic [6:0] bits);
        return (bits == COMMA_P) || (bits == COMMA_N);
    endfunction

    // Code group starting k bits below the top of the two-word window.
    function automatic logic [WORD_W-1:0] word_at(input logic [2*WORD_W-1:0] win,
                                                  input logic [3:0]          k);
        logic [2*WORD_W-1:0] shifted;
        shifted = win << k;
        return shifted[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/comma_aligner_8b10b_if.sv
// Raw-word input and aligned-word output bundle between deserializer, aligner and decoder.
interface comma_aligner_8b10b_if;
    import enc8b10b_pkg::*;

    logic              en;
    logic [WORD_W-1:0] din;
    logic              code_err;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              comma;
    logic              lock;
    logic [3:0]        align_off;

    modport master (
        output en, din, code_err,
        input  dout, dout_valid, comma, lock, align_off
    );

    modport slave (
        input  en, din, code_err,
        output dout, dout_valid, comma, lock, align_off
    );

endinterface

// File: rtl/comma_aligner_8b10b_detect.sv
// Searches all ten bit offsets of the {prev, din} window for a comma; lowest offset wins.
module comma_detect_8b10b
    import enc8b10b_pkg::*;
(
    input  logic [2*WORD_W-1:0] win,
    output logic [WORD_W-1:0]   match,
    output logic [3:0]          hit_off
);

    for (genvar k = 0; k < WORD_W; k++) begin : g_off
        assign match[k] = is_comma(win[2*WORD_W-1-k -: 7]);
    end

    // Scan downward so the lowest matching offset is the one left standing.
    always_comb begin
        hit_off = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (match[i]) hit_off = 4'(i);
        end
    end

endmodule

// File: rtl/comma_aligner_8b10b.sv
// Word aligner feeding decoder_8b10b: finds the K28.5 boundary and tracks sync with the decoder's code_err.
//   state | meaning
//   LOS   | no boundary; searching every offset for a comma
//   ACQ   | candidate offset found; counting consecutive commas there
//   SYNC  | locked; offset frozen, code errors tracked with leaky counter
module comma_aligner_8b10b
    import enc8b10b_pkg::*;
#(
    parameter int unsigned LOCK_COMMAS = 3,
    parameter int unsigned LOSS_ERRS   = 4,
    parameter int unsigned GOOD_RUN    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    comma_aligner_8b10b_if.slave   bus
);

    localparam int CC_W = $clog2(LOCK_COMMAS + 1);
    localparam int EC_W = $clog2(LOSS_ERRS + 1);
    localparam int GC_W = $clog2(GOOD_RUN + 1);

    localparam logic [CC_W-1:0] CC_ONE  = CC_W'(1);
    localparam logic [CC_W-1:0] CC_LAST = CC_W'(LOCK_COMMAS - 1);
    localparam logic [CC_W-1:0] CC_FULL = CC_W'(LOCK_COMMAS);
    localparam logic [EC_W-1:0] EC_ONE  = EC_W'(1);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(LOSS_ERRS - 1);
    localparam logic [EC_W-1:0] EC_FULL = EC_W'(LOSS_ERRS);
    localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GOOD_RUN - 1);

    sync_state_e         state;
    logic [WORD_W-1:0]   prev;
    logic [WORD_W-1:0]   dout_q;
    logic                dv_q;
    logic                comma_q;
    logic                lock_q;
    logic [3:0]          off_q;
    logic [CC_W-1:0]     comma_cnt;
    logic [EC_W-1:0]     err_cnt;
    logic [GC_W-1:0]     good_cnt;

    logic [2*WORD_W-1:0] win;
    logic [WORD_W-1:0]   match;
    logic [3:0]          hit_off;
    logic                any_hit;
    logic [WORD_W-1:0]   cur_word;
    logic                cur_comma;
    logic [WORD_W-1:0]   hit_word;

    assign win       = {prev, bus.din};
    assign any_hit   = |match;
    assign cur_word  = word_at(win, off_q);
    assign cur_comma = is_comma(cur_word[WORD_W-1:WORD_W-7]);
    assign hit_word  = word_at(win, hit_off);

    comma_detect_8b10b u_detect (
        .win     (win),
        .match   (match),
        .hit_off (hit_off)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOS;
            prev      <= '0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
            comma_q   <= 1'b0;
            lock_q    <= 1'b0;
            off_q     <= '0;
            comma_cnt <= '0;
            err_cnt   <= '0;
            good_cnt  <= '0;
        end else if (!bus.en) begin
            dv_q    <= 1'b0;
            comma_q <= 1'b0;
        end else begin
            prev    <= bus.din;
            dout_q  <= cur_word;
            comma_q <= cur_comma;
            unique case (state)
                LOS: begin
                    if (any_hit) begin
                        state     <= ACQ;
                        off_q     <= hit_off;
                        comma_cnt <= CC_ONE;
                        dout_q    <= hit_word;
                        comma_q   <= 1'b1;
                        dv_q      <= 1'b1;
                    end else begin
                        dv_q <= 1'b0;
                    end
                end
                ACQ: begin
                    if (bus.code_err) begin
                        state     <= LOS;
                        comma_cnt <= '0;
                        dv_q      <= 1'b0;
                    end else begin
                        dv_q <= 1'b1;
                        if (cur_comma) begin
                            if (comma_cnt == CC_LAST) begin
                                state     <= SYNC;
                                lock_q    <= 1'b1;
                                comma_cnt <= CC_FULL;
                                err_cnt   <= '0;
                                good_cnt  <= '0;
                            end else begin
                                comma_cnt <= comma_cnt + CC_ONE;
                            end
                        end else if (any_hit) begin
                            off_q     <= hit_off;
                            comma_cnt <= CC_ONE;
                            dout_q    <= hit_word;
                            comma_q   <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (bus.code_err) begin
                        good_cnt <= '0;
                        if (err_cnt == EC_LAST) begin
                            state   <= LOS;
                            lock_q  <= 1'b0;
                            dv_q    <= 1'b0;
                            err_cnt <= EC_FULL;
                        end else begin
                            err_cnt <= err_cnt + EC_ONE;
                            dv_q    <= 1'b1;
                        end
                    end else begin
                        dv_q <= 1'b1;
                        if (good_cnt == GC_LAST) begin
                            good_cnt <= '0;
                            if (err_cnt != '0) err_cnt <= err_cnt - EC_ONE;
                        end else begin
                            good_cnt <= good_cnt + GC_ONE;
                        end
                    end
                end
                default: state <= LOS;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.comma      = comma_q;
    assign bus.lock       = lock_q;
    assign bus.align_off  = off_q;

endmodule

// File: tb/tb_comma_aligner_8b10b.sv
// Self-checking bench: shifted K28.5 streams and random traffic against a word-level sync model.
module tb_comma_aligner_8b10b;
    import enc8b10b_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    comma_aligner_8b10b_if bus ();

    comma_aligner_8b10b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {bus.dout, bus.dout_valid, bus.comma, bus.lock, bus.align_off};

    // ---------------- reference model (word level, spec rules) ----------------
    int          m_state;   // 0 = no sync, 1 = acquiring, 2 = locked
    logic [9:0]  m_prev;
    int          m_off, m_cc, m_ec, m_gc;
    logic [9:0]  m_dout;
    logic        m_dv, m_comma, m_lock;
    logic [16:0] exp_v;

    // stream generator: 10-bit words delayed by an arbitrary bit offset
    logic [9:0]  s_last;
    bit          s_rd;

    function automatic logic comma_at(input logic [19:0] w, input int k);
        logic [19:0] s;
        s = w >> (13 - k);
        return (s[6:0] == 7'b0011111) || (s[6:0] == 7'b1100000);
    endfunction

    function automatic int first_comma(input logic [19:0] w);
        for (int k = 0; k < 10; k++) if (comma_at(w, k)) return k;
        return -1;
    endfunction

    function automatic logic [9:0] group_at(input logic [19:0] w, input int k);
        logic [19:0] s;
        s = w >> (10 - k);
        return s[9:0];
    endfunction

    task automatic m_reset();
        m_state = 0; m_prev = '0; m_off = 0; m_cc = 0; m_ec = 0; m_gc = 0;
        m_dout = '0; m_dv = 0; m_comma = 0; m_lock = 0;
        exp_v = '0;
    endtask

    task automatic model_step(input logic e, input logic [9:0] d, input logic er);
        logic [19:0] w;
        int h, ns, noff;
        if (!e) begin
            m_dv = 0;
            m_comma = 0;
        end else begin
            w = {m_prev, d};
            h = first_comma(w);
            ns = m_state;
            noff = m_off;
            if (m_state == 0) begin
                if (h >= 0) begin ns = 1; noff = h; m_cc = 1; end
            end else if (m_state == 1) begin
                if (er) ns = 0;
                else if (comma_at(w, m_off)) begin
                    m_cc++;
                    if (m_cc >= 3) begin ns = 2; m_ec = 0; m_gc = 0; end
                end else if (h >= 0) begin
                    noff = h; m_cc = 1;
                end
            end else begin
                if (er) begin
                    m_ec++; m_gc = 0;
                    if (m_ec >= 4) ns = 0;
                end else begin
                    m_gc++;
                    if (m_gc == 4) begin
                        m_gc = 0;
                        if (m_ec > 0) m_ec--;
                    end
                end
            end
            m_dout  = group_at(w, noff);
            m_comma = comma_at(w, noff);
            m_dv    = (ns != 0);
            m_lock  = (ns == 2);
            m_state = ns;
            m_off   = noff;
            m_prev  = d;
        end
        exp_v = {m_dout, m_dv, m_comma, m_lock, 4'(m_off)};
    endtask

    function automatic logic [9:0] kword();
        s_rd = ~s_rd;
        return s_rd ? K28_5_RDN : K28_5_RDP;
    endfunction

    task automatic next_raw(input logic [9:0] w, input int off, output logic [9:0] raw);
        logic [19:0] t;
        t = {s_last, w} >> off;
        raw = t[9:0];
        s_last = w;
    endtask

    task automatic cycle(input logic e, input logic [9:0] d, input logic er);
        bus.en = e; bus.din = d; bus.code_err = er;
        @(posedge clk);
        #1;
        model_step(e, d, er);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_reset();
        s_last = '0;
        s_rd = 1'b0;
        bus.en = 1'b0; bus.din = '0; bus.code_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        bus.en = 1'b1; bus.din = K28_5_RDN; bus.code_err = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, 17'h0);
        end
        do_reset();
    endtask

    task automatic test_aligned();
        logic [9:0] r;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            next_raw(kword(), 0, r);
            cycle(1'b1, r, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL aligned cyc %0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_cmp++;
        if (bus.align_off !== 4'd0 || bus.lock !== 1'b1 || bus.comma !== 1'b1) begin
            n_fail++;
            $display("FAIL aligned_lock: off=%0d lock=%b comma=%b want 0 1 1",
                     bus.align_off, bus.lock, bus.comma);
        end
    endtask

    task automatic test_offset3();
        logic [9:0] r;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            next_raw(kword(), 3, r);
            cycle(1'b1, r, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL offset3 cyc %0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_cmp++;
        if (bus.align_off !== 4'd3 || bus.lock !== 1'b1 ||
            !(bus.dout === K28_5_RDN || bus.dout === K28_5_RDP)) begin
            n_fail++;
            $display("FAIL offset3_lock: off=%0d lock=%b dout=%h want 3 1 K28.5",
                     bus.align_off, bus.lock, bus.dout);
        end
    endtask

    task automatic test_realign();
        logic [9:0] r;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            next_raw(kword(), (i < 2) ? 0 : 7, r);
            cycle(1'b1, r, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL realign cyc %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.lock !== 1'b0) begin
                    n_fail++;
                    $display("FAIL realign_early_lock: lock=%b want 0", bus.lock);
                end
            end
        end
        n_cmp++;
        if (bus.align_off !== 4'd7 || bus.lock !== 1'b1) begin
            n_fail++;
            $display("FAIL realign_final: off=%0d lock=%b want 7 1", bus.align_off, bus.lock);
        end
    endtask

    task automatic test_err_loss();
        logic [9:0] r;
        logic [12:0] errs;
        errs = 13'b1000100010001;
        do_reset();
        for (int i = 0; i < 6 + 15; i++) begin
            next_raw(kword(), 0, r);
            cycle(1'b1, r, (i >= 6 && i < 19) ? errs[i-6] : 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL err_loss cyc %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 18) begin
                n_cmp++;
                if (bus.lock !== 1'b0 || bus.dout_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_loss_drop: lock=%b dv=%b want 0 0", bus.lock, bus.dout_valid);
                end
            end
        end
    endtask

    task automatic test_err_recover();
        logic [9:0] r;
        logic er;
        do_reset();
        for (int i = 0; i < 6 + 3 + 12 + 1 + 3; i++) begin
            er = (i >= 6 && i < 9) || (i >= 21);
            next_raw(kword(), 0, r);
            cycle(1'b1, r, er);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL err_recover cyc %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 21 || i == 23) begin
                n_cmp++;
                if (bus.lock !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err_recover_hold cyc %0d: lock=%b want 1", i, bus.lock);
                end
            end
        end
        n_cmp++;
        if (bus.lock !== 1'b0) begin
            n_fail++;
            $display("FAIL err_recover_final: lock=%b want 0", bus.lock);
        end
    endtask

    task automatic test_reset_gaps();
        logic [9:0] r;
        logic e;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 20; i++) begin
                e = ($urandom_range(0, 9) < 7);
                if (e) next_raw(kword(), 0, r);
                else   r = 10'($urandom);
                cycle(e, r, 1'b0);
                n_cmp++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL gaps p%0d cyc %0d: got %h want %h", pass, i, obs, exp_v);
                end
            end
            if (pass == 0) begin
                #2;
                rst = 1'b0;
                #1;
                m_reset();
                n_cmp++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL async_reset: got %h want %h", obs, exp_v);
                end
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] r, w;
        logic e, er;
        int off;
        do_reset();
        off = $urandom_range(0, 9);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) off = $urandom_range(0, 9);
            e  = ($urandom_range(0, 7) != 0);
            er = ($urandom_range(0, 11) == 0);
            if (e) begin
                w = ($urandom_range(0, 3) == 0) ? 10'($urandom) : kword();
                next_raw(w, off, r);
            end else begin
                r = 10'($urandom);
            end
            cycle(e, r, er);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.din = '0; bus.code_err = 1'b0;
        m_reset();
        s_last = '0;
        s_rd = 1'b0;
        #2;
        test_reset();
        test_aligned();
        test_offset3();
        test_realign();
        test_err_loss();
        test_err_recover();
        test_reset_gaps();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
